// File: rtl/line_cmd_queue_if.sv
// Bus and LDA-side signals of the line command queue.
interface line_cmd_queue_if #(
   parameter int XW = 9,
   parameter int YW = 8,
   parameter int CW = 3
) ();
   logic          chipselect;
   logic [2:0]    address;
   logic          read;
   logic          write;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          waitrequest;
   logic          lda_go;
   logic          lda_done;
   logic [XW-1:0] lda_x0;
   logic [XW-1:0] lda_x1;
   logic [YW-1:0] lda_y0;
   logic [YW-1:0] lda_y1;
   logic [CW-1:0] lda_color;
   logic          irq;

   modport slave (
      input  chipselect, address, read, write, writedata, lda_done,
      output readdata, waitrequest, lda_go, lda_x0, lda_x1, lda_y0, lda_y1,
             lda_color, irq
   );

   modport master (
      output chipselect, address, read, write, writedata, lda_done,
      input  readdata, waitrequest, lda_go, lda_x0, lda_x1, lda_y0, lda_y1,
             lda_color, irq
   );
endinterface

// File: rtl/line_cmd_queue.sv
// Avalon-MM slave that stages line commands, queues them in a FIFO and
// dispatches them one at a time to the LDA datapath.
//
// state   | meaning
// S_IDLE  | no line in flight; pops the FIFO head when one is present
// S_ISSUE | lda_go pulse cycle for the line just popped
// S_BUSY  | waiting for lda_done
module line_cmd_queue #(
   parameter int XW    = 9,
   parameter int YW    = 8,
   parameter int CW    = 3,
   parameter int DEPTH = 4
) (
   input logic             CLOCK_50,
   input logic             Reset,
   line_cmd_queue_if.slave bus
);
   localparam int PW   = XW + YW;
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [1:0]      mode_r;
   logic [PW-1:0]   start_r, end_r;
   logic [CW-1:0]   color_r;
   logic            done_pend, ovf;
   logic [CNTW-1:0] count;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [PW-1:0]   mem_start [DEPTH];
   logic [PW-1:0]   mem_end   [DEPTH];
   logic [CW-1:0]   mem_color [DEPTH];
   logic [XW-1:0]   x0_r, x1_r;
   logic [YW-1:0]   y0_r, y1_r;
   logic [CW-1:0]   color_out_r;
   logic            go_pulse, pop;
   logic            wr_cs, rd_cs, go_wr, st_wr;
   logic            fifo_full, fifo_empty, push, stall, drop, done_set, idle;
   logic [31:0]     rdata;
   logic            unused_wdata;

   assign wr_cs      = bus.chipselect & bus.write;
   assign rd_cs      = bus.chipselect & bus.read;
   assign go_wr      = wr_cs && (bus.address == 3'd2);
   assign st_wr      = wr_cs && (bus.address == 3'd1);
   assign fifo_full  = (count == CNTW'(DEPTH));
   assign fifo_empty = (count == '0);
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign push       = go_wr && (!fifo_full || pop);
   assign stall      = go_wr && fifo_full && !pop && !mode_r[0];
   assign drop       = go_wr && fifo_full && !pop &&  mode_r[0];
   assign done_set   = (state == S_BUSY) && bus.lda_done && fifo_empty;
   assign idle       = fifo_empty && (state == S_IDLE);
   assign unused_wdata = ^bus.writedata;

   // Software-visible configuration and staging registers.
   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         mode_r  <= '0;
         start_r <= '0;
         end_r   <= '0;
         color_r <= '0;
      end else if (wr_cs) begin
         case (bus.address)
            3'd0:    mode_r  <= bus.writedata[1:0];
            3'd3:    start_r <= bus.writedata[PW-1:0];
            3'd4:    end_r   <= bus.writedata[PW-1:0];
            3'd5:    color_r <= bus.writedata[CW-1:0];
            default: ;
         endcase
      end
   end

   // Sticky status bits; a set in the same cycle as a W1C wins.
   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         done_pend <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         done_pend <= done_set | (done_pend & ~(st_wr & bus.writedata[2]));
         ovf       <= drop     | (ovf       & ~(st_wr & bus.writedata[3]));
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // FIFO storage: each entry is a snapshot of the staging registers.
   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         mem_start[wr_ptr] <= start_r;
         mem_end[wr_ptr]   <= end_r;
         mem_color[wr_ptr] <= color_r;
      end
   end

   // LDA operand registers, held from one pop to the next.
   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         x0_r        <= '0;
         y0_r        <= '0;
         x1_r        <= '0;
         y1_r        <= '0;
         color_out_r <= '0;
      end else if (pop) begin
         x0_r        <= mem_start[rd_ptr][XW-1:0];
         y0_r        <= mem_start[rd_ptr][PW-1:XW];
         x1_r        <= mem_end[rd_ptr][XW-1:0];
         y1_r        <= mem_end[rd_ptr][PW-1:XW];
         color_out_r <= mem_color[rd_ptr];
      end
   end

   // Dispatcher state register.
   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Dispatcher next state.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!fifo_empty) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_BUSY;
         S_BUSY:  if (bus.lda_done) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Dispatcher outputs.
   always_comb begin
      go_pulse = (state == S_ISSUE);
      pop      = (state == S_IDLE) && !fifo_empty;
   end

   // Combinational read mux.
   always_comb begin
      rdata = '0;
      if (rd_cs) begin
         case (bus.address)
            3'd0: rdata[1:0] = mode_r;
            3'd1: begin
               rdata[0]          = idle;
               rdata[1]          = fifo_full;
               rdata[2]          = done_pend;
               rdata[3]          = ovf;
               rdata[8 +: CNTW]  = count;
            end
            3'd3:    rdata[PW-1:0] = start_r;
            3'd4:    rdata[PW-1:0] = end_r;
            3'd5:    rdata[CW-1:0] = color_r;
            default: rdata = '0;
         endcase
      end
   end

   assign bus.readdata    = rdata;
   assign bus.waitrequest = stall;
   assign bus.lda_go      = go_pulse;
   assign bus.lda_x0      = x0_r;
   assign bus.lda_y0      = y0_r;
   assign bus.lda_x1      = x1_r;
   assign bus.lda_y1      = y1_r;
   assign bus.lda_color   = color_out_r;
   assign bus.irq         = done_pend & mode_r[1];
endmodule

// File: tb/tb_line_cmd_queue.sv
// Bench for line_cmd_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_line_cmd_queue;
   localparam int XW = 9, YW = 8, CW = 3, DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   line_cmd_queue_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

   line_cmd_queue #(.XW(XW), .YW(YW), .CW(CW), .DEPTH(DEPTH)) dut (
      .CLOCK_50 (clk),
      .Reset    (rst),
      .bus      (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int go_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {int x0; int y0; int x1; int y1; int c;} cmd_t;
   cmd_t mq[$];
   int   m_mode, m_sx, m_sy, m_ex, m_ey, m_col;
   int   m_ox0, m_oy0, m_ox1, m_oy1, m_oc;
   bit   m_dp, m_ov, m_active, m_gopend;

   task automatic model_reset();
      mq.delete();
      m_mode = 0; m_sx = 0; m_sy = 0; m_ex = 0; m_ey = 0; m_col = 0;
      m_ox0 = 0; m_oy0 = 0; m_ox1 = 0; m_oy1 = 0; m_oc = 0;
      m_dp = 0; m_ov = 0; m_active = 0; m_gopend = 0;
   endtask

   always @(posedge clk) if (bus.lda_go === 1'b1) go_seen++;

   always @(negedge clk) begin
      logic [31:0] wd, erd;
      int   addr, sz;
      bit   cs, wr_s, rd_s, gw, full, popm, accept, dset, oset, st_w;
      cmd_t c;
      if (rst) model_reset();
      cs = bus.chipselect; wr_s = bus.write; rd_s = bus.read;
      addr = int'(bus.address); wd = bus.writedata;
      sz   = mq.size();
      full = (sz == DEPTH);
      popm = !m_active && sz > 0;
      gw   = cs && wr_s && addr == 2;
      erd  = 0;
      if (cs && rd_s) begin
         case (addr)
            0: erd = m_mode;
            1: erd = ((sz == 0 && !m_active) ? 1 : 0) + (full ? 2 : 0) +
                     (m_dp ? 4 : 0) + (m_ov ? 8 : 0) + sz * 256;
            3: erd = m_sx + m_sy * (1 << XW);
            4: erd = m_ex + m_ey * (1 << XW);
            5: erd = m_col;
            default: erd = 0;
         endcase
      end
      chk("readdata", bus.readdata, erd);
      chk("waitrequest", 32'(bus.waitrequest), 32'(gw && full && !popm && (m_mode % 2 == 0)));
      chk("lda_go", 32'(bus.lda_go), 32'(m_gopend));
      chk("irq", 32'(bus.irq), 32'(m_dp && (m_mode & 2) != 0));
      chk("lda_x0", 32'(bus.lda_x0), m_ox0);
      chk("lda_y0", 32'(bus.lda_y0), m_oy0);
      chk("lda_x1", 32'(bus.lda_x1), m_ox1);
      chk("lda_y1", 32'(bus.lda_y1), m_oy1);
      chk("lda_color", 32'(bus.lda_color), m_oc);
      if (!rst) begin
         accept = m_active && !m_gopend && bus.lda_done;
         dset   = accept && sz == 0;
         oset   = gw && full && !popm && (m_mode % 2 == 1);
         st_w   = cs && wr_s && addr == 1;
         m_gopend = 0;
         if (accept) m_active = 0;
         if (popm) begin
            c = mq.pop_front();
            m_ox0 = c.x0; m_oy0 = c.y0; m_ox1 = c.x1; m_oy1 = c.y1; m_oc = c.c;
            m_active = 1; m_gopend = 1;
         end
         if (gw && (!full || popm)) mq.push_back('{m_sx, m_sy, m_ex, m_ey, m_col});
         if (st_w && wd[2]) m_dp = 0;
         if (st_w && wd[3]) m_ov = 0;
         if (dset) m_dp = 1;
         if (oset) m_ov = 1;
         if (cs && wr_s) begin
            case (addr)
               0: m_mode = int'(wd & 3);
               3: begin m_sx = int'(wd) % (1 << XW); m_sy = (int'(wd) >> XW) % (1 << YW); end
               4: begin m_ex = int'(wd) % (1 << XW); m_ey = (int'(wd) >> XW) % (1 << YW); end
               5: m_col = int'(wd) % (1 << CW);
               default: ;
            endcase
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wr(input int addr, input int data, output int stalls);
      stalls = 0;
      bus.chipselect = 1; bus.write = 1; bus.address = 3'(addr); bus.writedata = data;
      @(negedge clk);
      while (bus.waitrequest && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 200) begin
         n_cmp++; n_fail++;
         $display("FAIL wr_timeout: waitrequest still 1 after %0d cycles, required 0", stalls);
      end
      @(posedge clk); #1;
      bus.chipselect = 0; bus.write = 0; bus.address = 0; bus.writedata = 0;
   endtask

   task automatic wr1(input int addr, input int data);
      int s;
      wr(addr, data, s);
   endtask

   task automatic rd(input int addr, output logic [31:0] d);
      bus.chipselect = 1; bus.read = 1; bus.address = 3'(addr);
      @(negedge clk);
      d = bus.readdata;
      @(posedge clk); #1;
      bus.chipselect = 0; bus.read = 0; bus.address = 0;
   endtask

   task automatic pulse_done();
      bus.lda_done = 1;
      @(posedge clk); #1;
      bus.lda_done = 0;
   endtask

   task automatic wait_go(input int target);
      int n;
      n = 0;
      while (go_seen < target && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (go_seen < target) begin
         n_cmp++; n_fail++;
         $display("FAIL go_timeout: saw %0d lda_go pulses, required %0d", go_seen, target);
      end
   endtask

   task automatic stage(input int sx, input int sy, input int ex, input int ey, input int c);
      wr1(3, sx + (sy << XW));
      wr1(4, ex + (ey << XW));
      wr1(5, c);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      logic [31:0] d;
      int stalls, base;
      bus.chipselect = 0; bus.read = 0; bus.write = 0; bus.address = 0;
      bus.writedata = 0; bus.lda_done = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Reset state
      rd(0, d); chk("mode_reset", d, 32'h0);
      rd(1, d); chk("status_reset", d, 32'h1);
      @(negedge clk);
      chk("go_reset", 32'(bus.lda_go), 32'h0);
      chk("irq_reset", 32'(bus.irq), 32'h0);
      @(posedge clk); #1;
      bus.read = 1; bus.address = 1;
      @(negedge clk); chk("read_no_cs", bus.readdata, 32'h0);
      @(posedge clk); #1; bus.read = 0; bus.address = 0;

      // Single command and its latency
      stage(10, 20, 300, 200, 5);
      wr1(2, 0);
      @(negedge clk); chk("go_t1", 32'(bus.lda_go), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("go_t2", 32'(bus.lda_go), 32'h1);
      chk("x0_first", 32'(bus.lda_x0), 32'd10);
      chk("y0_first", 32'(bus.lda_y0), 32'd20);
      chk("x1_first", 32'(bus.lda_x1), 32'd300);
      chk("y1_first", 32'(bus.lda_y1), 32'd200);
      chk("color_first", 32'(bus.lda_color), 32'd5);
      @(posedge clk); #1;
      rd(1, d); chk("status_busy", d, 32'h0);
      pulse_done();
      rd(1, d); chk("status_done", d, 32'h5);
      wr1(1, 4);

      // Stall mode fill and stalled push
      for (int i = 0; i < 5; i++) begin
         stage(11 + i, 21 + i, 290 - i, 190 - i, i);
         wr1(2, 0);
      end
      rd(1, d); chk("status_full_stall", d, 32'h402);
      stage(50, 60, 70, 80, 7);
      base = go_seen;
      fork
         wr(2, 0, stalls);
         begin
            repeat (3) @(negedge clk);
            chk("wait_high", 32'(bus.waitrequest), 32'h1);
            @(posedge clk); #1;
            pulse_done();
         end
      join
      chk("stall_cycles", stalls, 32'd4);
      for (int i = 0; i < 5; i++) begin
         wait_go(base + 1 + i);
         pulse_done();
      end
      chk("last_x0", 32'(bus.lda_x0), 32'd50);
      rd(1, d); chk("status_drained", d, 32'h5);
      wr1(1, 4);

      // Poll mode overflow
      wr1(0, 1);
      rd(0, d); chk("mode_poll", d, 32'h1);
      base = go_seen;
      for (int i = 0; i < 5; i++) begin
         stage(100 + i, 30 + i, 400 - i, 250 - i, 7 - i);
         wr1(2, 0);
      end
      wr(2, 0, stalls);
      chk("poll_no_stall", stalls, 32'd0);
      rd(1, d); chk("status_ovf", d, 32'h40A);
      wr1(1, 8);
      rd(1, d); chk("status_ovf_clr", d, 32'h402);
      for (int i = 0; i < 5; i++) begin
         wait_go(base + 1 + i);
         pulse_done();
      end
      repeat (6) @(posedge clk);
      #1;
      chk("poll_go_count", go_seen - base, 32'd5);
      rd(1, d); chk("status_poll_end", d, 32'h5);
      wr1(1, 4);

      // Batch-complete interrupt
      wr1(0, 2);
      base = go_seen;
      for (int i = 0; i < 3; i++) wr1(2, 0);
      for (int i = 0; i < 3; i++) begin
         wait_go(base + 1 + i);
         chk("irq_before_last", 32'(bus.irq), 32'h0);
         pulse_done();
      end
      @(negedge clk); chk("irq_after_3", 32'(bus.irq), 32'h1);
      @(posedge clk); #1;
      wr1(1, 4);
      @(negedge clk); chk("irq_cleared", 32'(bus.irq), 32'h0);
      @(posedge clk); #1;

      // Reset in flight
      base = go_seen;
      for (int i = 0; i < 3; i++) wr1(2, 0);
      wait_go(base + 1);
      rd(1, d); chk("status_pre_reset", d, 32'h200);
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      rd(1, d); chk("status_post_reset", d, 32'h1);
      rd(0, d); chk("mode_post_reset", d, 32'h0);
      base = go_seen;
      repeat (20) @(posedge clk);
      #1;
      chk("no_go_after_reset", go_seen - base, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
